// File: rtl/matmul_pkg.sv
// Shared types and default widths for the matrix-multiply sequencer and its datapath.
package matmul_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DIM_W_DEF  = 4;
  localparam int unsigned CNT_W_DEF  = 2 * DIM_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_WB = 2'd2,
    ST_DONE    = 2'd3
  } seq_state_e;

  // One operand tuple as seen by the MAC datapath.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] a_addr;
    logic [ADDR_W_DEF-1:0] b_addr;
    logic [ADDR_W_DEF-1:0] c_addr;
    logic                  first;
    logic                  last;
  } op_tuple_t;

endpackage

// File: rtl/matmul_sequencer_if.sv
// Operand-issue handshake and write-back acknowledge between sequencer and MAC datapath.
interface matmul_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  op_valid;
  logic                  op_ready;
  logic [ADDR_WIDTH-1:0] op_a_addr;
  logic [ADDR_WIDTH-1:0] op_b_addr;
  logic [ADDR_WIDTH-1:0] op_c_addr;
  logic                  op_first;
  logic                  op_last;
  logic                  wb_ack;

  modport master (
    output op_valid, op_a_addr, op_b_addr, op_c_addr, op_first, op_last,
    input  op_ready, wb_ack
  );

  modport slave (
    input  op_valid, op_a_addr, op_b_addr, op_c_addr, op_first, op_last,
    output op_ready, wb_ack
  );
endinterface

// File: rtl/matmul_addr_gen.sv
// i/j/k loop counters with multiplier-free incremental A/B/C address generation.
module matmul_addr_gen
  import matmul_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
  parameter int unsigned DIM_WIDTH  = DIM_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  advance_i,
  input  logic [ADDR_WIDTH-1:0] a_base_i,
  input  logic [ADDR_WIDTH-1:0] b_base_i,
  input  logic [ADDR_WIDTH-1:0] c_base_i,
  input  logic [DIM_WIDTH-1:0]  dim_n_i,
  input  logic [DIM_WIDTH-1:0]  dim_m_i,
  input  logic [DIM_WIDTH-1:0]  dim_p_i,
  output logic [ADDR_WIDTH-1:0] a_addr_o,
  output logic [ADDR_WIDTH-1:0] b_addr_o,
  output logic [ADDR_WIDTH-1:0] c_addr_o,
  output logic                  first_o,
  output logic                  last_o,
  output logic                  last_op_o
);

  logic [DIM_WIDTH-1:0]  n_q, n_d, m_q, m_d, p_q, p_d;
  logic [DIM_WIDTH-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [ADDR_WIDTH-1:0] a_row_q, a_row_d, b_col_q, b_col_d, b_base_q, b_base_d;
  logic                  first_q, first_d, last_q, last_d, last_op_q, last_op_d;
  logic                  k_end, j_end, i_end;

  assign k_end = (k_q == m_q - DIM_WIDTH'(1));
  assign j_end = (j_q == p_q - DIM_WIDTH'(1));
  assign i_end = (i_q == n_q - DIM_WIDTH'(1));

  // Row-major walk: k fastest, then j, then i; flags are precomputed for the next tuple.
  always_comb begin
    n_d      = n_q;
    m_d      = m_q;
    p_d      = p_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    a_row_d  = a_row_q;
    b_col_d  = b_col_q;
    b_base_d = b_base_q;
    if (load_i) begin
      n_d      = dim_n_i;
      m_d      = dim_m_i;
      p_d      = dim_p_i;
      i_d      = '0;
      j_d      = '0;
      k_d      = '0;
      a_d      = a_base_i;
      a_row_d  = a_base_i;
      b_d      = b_base_i;
      b_col_d  = b_base_i;
      b_base_d = b_base_i;
      c_d      = c_base_i;
    end else if (advance_i) begin
      if (!k_end) begin
        k_d = k_q + DIM_WIDTH'(1);
        a_d = a_q + ADDR_WIDTH'(1);
        b_d = b_q + ADDR_WIDTH'(p_q);
      end else if (!j_end) begin
        k_d     = '0;
        j_d     = j_q + DIM_WIDTH'(1);
        a_d     = a_row_q;
        b_col_d = b_col_q + ADDR_WIDTH'(1);
        b_d     = b_col_q + ADDR_WIDTH'(1);
        c_d     = c_q + ADDR_WIDTH'(1);
      end else if (!i_end) begin
        k_d     = '0;
        j_d     = '0;
        i_d     = i_q + DIM_WIDTH'(1);
        a_row_d = a_row_q + ADDR_WIDTH'(m_q);
        a_d     = a_row_q + ADDR_WIDTH'(m_q);
        b_col_d = b_base_q;
        b_d     = b_base_q;
        c_d     = c_q + ADDR_WIDTH'(1);
      end
    end
    first_d   = (k_d == '0);
    last_d    = (k_d == m_d - DIM_WIDTH'(1));
    last_op_d = last_d && (j_d == p_d - DIM_WIDTH'(1)) && (i_d == n_d - DIM_WIDTH'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q       <= '0;
      m_q       <= '0;
      p_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      a_row_q   <= '0;
      b_col_q   <= '0;
      b_base_q  <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      last_op_q <= 1'b0;
    end else begin
      n_q       <= n_d;
      m_q       <= m_d;
      p_q       <= p_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      a_row_q   <= a_row_d;
      b_col_q   <= b_col_d;
      b_base_q  <= b_base_d;
      first_q   <= first_d;
      last_q    <= last_d;
      last_op_q <= last_op_d;
    end
  end

  assign a_addr_o  = a_q;
  assign b_addr_o  = b_q;
  assign c_addr_o  = c_q;
  assign first_o   = first_q;
  assign last_o    = last_q;
  assign last_op_o = last_op_q;

endmodule

// File: rtl/matmul_sequencer.sv
// Loop-nest controller for the matmul MAC datapath: issues operand tuples, counts write-backs.
// Optional busy/stall performance counters are built when MATMUL_SEQ_PERF_EN is defined.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
  parameter int unsigned DIM_WIDTH  = DIM_W_DEF,
  parameter int unsigned CNT_WIDTH  = 2 * DIM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] a_base,
  input  logic [ADDR_WIDTH-1:0] b_base,
  input  logic [ADDR_WIDTH-1:0] c_base,
  input  logic [DIM_WIDTH-1:0]  dim_n,
  input  logic [DIM_WIDTH-1:0]  dim_m,
  input  logic [DIM_WIDTH-1:0]  dim_p,
  matmul_sequencer_if.master    op_if,
  output logic                  busy,
  output logic                  done
`ifdef MATMUL_SEQ_PERF_EN
  ,
  output logic [CNT_WIDTH+8-1:0] perf_cycles,
  output logic [CNT_WIDTH+8-1:0] perf_stalls
`endif
);

  seq_state_e           state_q, state_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] wb_cnt_q, wb_cnt_d, wb_cnt_inc;
  logic [CNT_WIDTH-1:0] np_q, np_d;
  logic                 load, advance, last_op;
  logic                 dims_zero;

  assign wb_cnt_inc = wb_cnt_q + CNT_WIDTH'(op_if.wb_ack);
  assign dims_zero  = (dim_n == '0) || (dim_m == '0) || (dim_p == '0);

  matmul_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .advance_i (advance),
    .a_base_i  (a_base),
    .b_base_i  (b_base),
    .c_base_i  (c_base),
    .dim_n_i   (dim_n),
    .dim_m_i   (dim_m),
    .dim_p_i   (dim_p),
    .a_addr_o  (op_if.op_a_addr),
    .b_addr_o  (op_if.op_b_addr),
    .c_addr_o  (op_if.op_c_addr),
    .first_o   (op_if.op_first),
    .last_o    (op_if.op_last),
    .last_op_o (last_op)
  );

  // Next-state and registered-output decode; acks are counted in every non-idle state.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    advance  = 1'b0;
    wb_cnt_d = wb_cnt_q;
    np_d     = np_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load     = 1'b1;
          np_d     = CNT_WIDTH'(dim_n) * CNT_WIDTH'(dim_p);
          wb_cnt_d = '0;
          state_d  = dims_zero ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (op_if.op_ready) begin
          advance = 1'b1;
          if (last_op) state_d = ST_WAIT_WB;
        end
      end
      ST_WAIT_WB: begin
        if (wb_cnt_inc >= np_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if ((state_q != ST_IDLE) && op_if.wb_ack) wb_cnt_d = wb_cnt_inc;
    valid_d = (state_d == ST_ISSUE);
    busy_d  = (state_d == ST_ISSUE) || (state_d == ST_WAIT_WB);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wb_cnt_q <= '0;
      np_q     <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wb_cnt_q <= wb_cnt_d;
      np_q     <= np_d;
    end
  end

  assign op_if.op_valid = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;

`ifdef MATMUL_SEQ_PERF_EN
  localparam int unsigned PERF_W = CNT_WIDTH + 8;

  logic [PERF_W-1:0] perf_cycles_q, perf_cycles_d;
  logic [PERF_W-1:0] perf_stalls_q, perf_stalls_d;

  // Saturating counters, cleared on job start and held once the job ends.
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    if (load) begin
      perf_cycles_d = '0;
      perf_stalls_d = '0;
    end else begin
      if (busy_q && !(&perf_cycles_q)) perf_cycles_d = perf_cycles_q + PERF_W'(1);
      if (valid_q && !op_if.op_ready && !(&perf_stalls_q))
        perf_stalls_d = perf_stalls_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: job table with expected tuple streams plus reset/stall corner cases.
module tb_matmul_sequencer;
  import matmul_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 4;
  localparam int unsigned CW = 8;

  typedef struct {
    logic [AW-1:0] a_base;
    logic [AW-1:0] b_base;
    logic [AW-1:0] c_base;
    logic [DW-1:0] n;
    logic [DW-1:0] m;
    logic [DW-1:0] p;
    int            ready_mode;
    bit            spurious;
    int            exp_idx;
    int            n_ops;
  } job_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] a_base, b_base, c_base;
  logic [DW-1:0] dim_n, dim_m, dim_p;
  logic          busy, done;
`ifdef MATMUL_SEQ_PERF_EN
  logic [CW+7:0] perf_cycles, perf_stalls;
`endif

  matmul_sequencer_if #(.ADDR_WIDTH(AW)) op_if ();

  matmul_sequencer #(
    .ADDR_WIDTH (AW),
    .DIM_WIDTH  (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a_base (a_base),
    .b_base (b_base),
    .c_base (c_base),
    .dim_n  (dim_n),
    .dim_m  (dim_m),
    .dim_p  (dim_p),
    .op_if  (op_if),
    .busy   (busy),
    .done   (done)
`ifdef MATMUL_SEQ_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_stalls (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cyc = 0, done_cnt = 0, done_cyc = -1, ack_cyc = -100;
  int busy_cyc = 0, valid_cyc = 0, stall_cyc = 0;
  int ready_mode = 0;
  op_tuple_t cap[$];
  op_tuple_t exp_tab[18];
  job_t      jobs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
    end
  endtask

  // Datapath model: drives op_ready, returns wb_ack two cycles after each op_last handshake.
  initial begin
    bit        tog;
    bit        prev_stall;
    bit [1:0]  ack_pipe;
    logic      rdy, hs_last;
    op_tuple_t cur, prev_t;
    tog = 1'b0;
    prev_stall = 1'b0;
    ack_pipe = 2'b00;
    prev_t = '0;
    op_if.op_ready = 1'b0;
    op_if.wb_ack = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        ack_pipe = 2'b00;
        op_if.wb_ack = 1'b0;
        op_if.op_ready = 1'b0;
        prev_stall = 1'b0;
        continue;
      end
      cur = '{op_if.op_a_addr, op_if.op_b_addr, op_if.op_c_addr, op_if.op_first, op_if.op_last};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cyc++;
      if (op_if.op_valid) valid_cyc++;
      if (prev_stall) begin
        chk("stall_valid_held", 64'(op_if.op_valid), 64'd1);
        chk("stall_tuple_held", 64'(cur), 64'(prev_t));
      end
      if (ready_mode == 0) rdy = 1'b1;
      else begin
        tog = ~tog;
        rdy = tog;
      end
      op_if.op_ready = rdy;
      hs_last = 1'b0;
      if (op_if.op_valid && rdy) begin
        cap.push_back(cur);
        hs_last = cur.last;
      end
      prev_stall = op_if.op_valid && !rdy;
      if (prev_stall) stall_cyc++;
      prev_t = cur;
      op_if.wb_ack = ack_pipe[1];
      if (ack_pipe[1]) ack_cyc = cyc;
      ack_pipe = {ack_pipe[0], hs_last};
    end
  end

  task automatic run_job(input job_t jb, input int id);
    int start_cyc;
    cap.delete();
    done_cnt = 0;
    busy_cyc = 0;
    valid_cyc = 0;
    stall_cyc = 0;
    ack_cyc = -100;
    done_cyc = -1;
    ready_mode = jb.ready_mode;
    a_base = jb.a_base;
    b_base = jb.b_base;
    c_base = jb.c_base;
    dim_n = jb.n;
    dim_m = jb.m;
    dim_p = jb.p;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    #1;
    start = 1'b0;
    if (jb.n_ops > 0) begin
      chk($sformatf("job%0d first_valid_latency", id), 64'(op_if.op_valid), 64'd1);
      chk($sformatf("job%0d busy_after_start", id), 64'(busy), 64'd1);
    end
    for (int c = 0; c < 500 && done_cnt == 0; c++) begin
      if (jb.spurious) begin
        start = busy && (c % 2 == 0);
        a_base = 12'h123;
        b_base = 12'h456;
      end
      @(negedge clk);
      #1;
    end
    start = 1'b0;
    chk($sformatf("job%0d done_seen", id), 64'(done_cnt != 0), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    chk($sformatf("job%0d done_pulses", id), 64'(done_cnt), 64'd1);
    chk($sformatf("job%0d busy_idle", id), 64'(busy), 64'd0);
    chk($sformatf("job%0d op_count", id), 64'(cap.size()), 64'(jb.n_ops));
    for (int k = 0; k < jb.n_ops; k++) begin
      if (k < cap.size())
        chk($sformatf("job%0d op%0d tuple", id, k), 64'(cap[k]), 64'(exp_tab[jb.exp_idx + k]));
    end
    if (jb.n_ops > 0) begin
      chk($sformatf("job%0d ack_to_done", id), 64'(done_cyc - ack_cyc), 64'd1);
    end else begin
      chk($sformatf("job%0d zero_busy", id), 64'(busy_cyc), 64'd0);
      chk($sformatf("job%0d zero_valid", id), 64'(valid_cyc), 64'd0);
      chk($sformatf("job%0d zero_done_latency", id),
          64'((done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2)), 64'd1);
    end
    if (jb.ready_mode != 0)
      chk($sformatf("job%0d stalls_seen", id), 64'(stall_cyc > 0), 64'd1);
`ifdef MATMUL_SEQ_PERF_EN
    chk($sformatf("job%0d perf_stalls", id), 64'(perf_stalls), 64'(stall_cyc));
    chk($sformatf("job%0d perf_cycles", id), 64'(perf_cycles), 64'(busy_cyc));
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_base = '0;
    b_base = '0;
    c_base = '0;
    dim_n = '0;
    dim_m = '0;
    dim_p = '0;

    // 2x2x2, bases 0x000/0x100/0x200
    exp_tab[0]  = '{12'h000, 12'h100, 12'h200, 1'b1, 1'b0};
    exp_tab[1]  = '{12'h001, 12'h102, 12'h200, 1'b0, 1'b1};
    exp_tab[2]  = '{12'h000, 12'h101, 12'h201, 1'b1, 1'b0};
    exp_tab[3]  = '{12'h001, 12'h103, 12'h201, 1'b0, 1'b1};
    exp_tab[4]  = '{12'h002, 12'h100, 12'h202, 1'b1, 1'b0};
    exp_tab[5]  = '{12'h003, 12'h102, 12'h202, 1'b0, 1'b1};
    exp_tab[6]  = '{12'h002, 12'h101, 12'h203, 1'b1, 1'b0};
    exp_tab[7]  = '{12'h003, 12'h103, 12'h203, 1'b0, 1'b1};
    // N=3 M=1 P=2, bases 0x010/0x020/0x030
    exp_tab[8]  = '{12'h010, 12'h020, 12'h030, 1'b1, 1'b1};
    exp_tab[9]  = '{12'h010, 12'h021, 12'h031, 1'b1, 1'b1};
    exp_tab[10] = '{12'h011, 12'h020, 12'h032, 1'b1, 1'b1};
    exp_tab[11] = '{12'h011, 12'h021, 12'h033, 1'b1, 1'b1};
    exp_tab[12] = '{12'h012, 12'h020, 12'h034, 1'b1, 1'b1};
    exp_tab[13] = '{12'h012, 12'h021, 12'h035, 1'b1, 1'b1};
    // N=1 M=4 P=1, A wraps past 0xFFF
    exp_tab[14] = '{12'hFFE, 12'h400, 12'h500, 1'b1, 1'b0};
    exp_tab[15] = '{12'hFFF, 12'h401, 12'h500, 1'b0, 1'b0};
    exp_tab[16] = '{12'h000, 12'h402, 12'h500, 1'b0, 1'b0};
    exp_tab[17] = '{12'h001, 12'h403, 12'h500, 1'b0, 1'b1};

    jobs[0] = '{12'h000, 12'h100, 12'h200, 4'd2, 4'd2, 4'd2, 0, 1'b0, 0, 8};
    jobs[1] = '{12'h000, 12'h100, 12'h200, 4'd2, 4'd2, 4'd2, 1, 1'b0, 0, 8};
    jobs[2] = '{12'h010, 12'h020, 12'h030, 4'd3, 4'd1, 4'd2, 0, 1'b0, 8, 6};
    jobs[3] = '{12'h010, 12'h020, 12'h030, 4'd2, 4'd0, 4'd2, 0, 1'b0, 0, 0};
    jobs[4] = '{12'hFFE, 12'h400, 12'h500, 4'd1, 4'd4, 4'd1, 0, 1'b1, 14, 4};

    repeat (3) @(negedge clk);
    #1;
    chk("reset op_valid", 64'(op_if.op_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset a_addr", 64'(op_if.op_a_addr), 64'd0);
    chk("reset b_addr", 64'(op_if.op_b_addr), 64'd0);
    chk("reset c_addr", 64'(op_if.op_c_addr), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    for (int j = 0; j < 5; j++) run_job(jobs[j], j);

    // Reset while the third tuple of a 2x2x2 job is on the bus
    cap.delete();
    done_cnt = 0;
    ready_mode = 0;
    a_base = 12'h000;
    b_base = 12'h100;
    c_base = 12'h200;
    dim_n = 4'd2;
    dim_m = 4'd2;
    dim_p = 4'd2;
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 50 && cap.size() < 3; c++) begin
      @(negedge clk);
      #1;
    end
    chk("midjob reached tuple3", 64'(cap.size() >= 3), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midjob reset op_valid", 64'(op_if.op_valid), 64'd0);
    chk("midjob reset busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("midjob no stale done", 64'(done_cnt), 64'd0);
    run_job(jobs[0], 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, want finish");
    $fatal(1, "timeout");
  end

endmodule
